vend_ctrl_param: RTL and testbench

//  Parametrised coin-vending controller, next generation of the project's penny/farthing machine.
//  - Accumulates credit from penny, farthing and half-farthing coins.
//  - Vends one item when credit reaches PRICE.
//  - Returns change one coin per handshake, largest coin first.
//  - Supports cancel and refund.
//  - Sits between the debounced coin encoder and the 7-segment/LED output logic.

---
 rtl/vend_if.sv | 32 +++
 rtl/vend_ctrl_param.sv | 93 +++++++++
 tb/tb_vend_ctrl_param.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vend_if.sv
// vend_if: coin-in / change-out handshake bundle for vend_ctrl_param.
// Carries sales_cnt only when SALES_CNT_EN is defined.
interface vend_if #(parameter int CREDIT_W = 6);
  logic                coin_vld;
  logic [1:0]          coin_typ;
  logic                cancel;
  logic                coin_rdy;
  logic                coin_rej;
  logic                item;
  logic                chg_vld;
  logic [1:0]          chg_typ;
  logic                chg_rdy;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
`ifdef SALES_CNT_EN
  logic [15:0]         sales_cnt;
`endif
  modport slave (
    input  coin_vld, coin_typ, cancel, chg_rdy,
    output coin_rdy, coin_rej, item, chg_vld, chg_typ, credit, busy
`ifdef SALES_CNT_EN
    , output sales_cnt
`endif
  );
  modport master (
    output coin_vld, coin_typ, cancel, chg_rdy,
    input  coin_rdy, coin_rej, item, chg_vld, chg_typ, credit, busy
`ifdef SALES_CNT_EN
    , input sales_cnt
`endif
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised penny/farthing/half-farthing vending controller with largest-first change.
// Optional saturating sales counter enabled by defining SALES_CNT_EN.
module vend_ctrl_param #(
  parameter int CREDIT_W = 6,
  parameter int PRICE    = 16,
  parameter int PEN_VAL  = 8,
  parameter int FA_VAL   = 2,
  parameter int HFA_VAL  = 1
) (
  input logic   CLK,
  input logic   RES,
  vend_if.slave bus
);
  localparam int MAX = (1 << CREDIT_W) - 1;
  localparam int W   = CREDIT_W + 1;
  if (CREDIT_W < 2 || CREDIT_W > 30) begin : g_bad_width
    $error("vend_ctrl_param: CREDIT_W out of range");
  end
  if (PRICE < 1 || PRICE > MAX) begin : g_bad_price
    $error("vend_ctrl_param: PRICE must be within 1..2**CREDIT_W-1");
  end
  // a unit half-farthing guarantees change can always drain credit to zero
  if (HFA_VAL != 1 || FA_VAL <= HFA_VAL || PEN_VAL <= FA_VAL || PEN_VAL > MAX) begin : g_bad_coins
    $error("vend_ctrl_param: coin values must satisfy 1 == HFA_VAL < FA_VAL < PEN_VAL <= max credit");
  end
  typedef enum logic [1:0] {ACCUM, VEND, CHANGE} state_t;
  state_t              state;
  logic [CREDIT_W-1:0] credit;
  logic                coin_rej;
  logic                coin_in;
  logic [1:0]          sel;
  logic [W-1:0]        cur, coin_val, chg_val, sum, rem, left;
  function automatic logic [W-1:0] val_of(input logic [1:0] t);
    return t == 2'b11 ? W'(PEN_VAL) : t == 2'b10 ? W'(FA_VAL) : t == 2'b01 ? W'(HFA_VAL) : '0;
  endfunction
  always_comb begin
    cur      = {1'b0, credit};
    coin_in  = bus.coin_vld && bus.coin_typ != 2'b00;
    coin_val = val_of(bus.coin_typ);
    sum      = cur + coin_val;
    rem      = cur - W'(PRICE);
    sel      = cur >= W'(PEN_VAL) ? 2'b11 : cur >= W'(FA_VAL) ? 2'b10 : cur >= W'(HFA_VAL) ? 2'b01 : 2'b00;
    chg_val  = val_of(sel);
    left     = cur - chg_val;
  end
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state    <= ACCUM;
      credit   <= '0;
      coin_rej <= 1'b0;
    end else begin
      coin_rej <= 1'b0;
      case (state)
        ACCUM: begin
          if (bus.cancel && credit != '0) begin
            state    <= CHANGE;
            coin_rej <= coin_in;
          end else begin
            if (cur >= W'(PRICE)) state <= VEND;
            if (coin_in && sum > W'(MAX)) coin_rej <= 1'b1;
            else if (coin_in) credit <= sum[CREDIT_W-1:0];
          end
        end
        VEND: begin
          coin_rej <= coin_in;
          credit   <= rem[CREDIT_W-1:0];
          state    <= rem != '0 ? CHANGE : ACCUM;
        end
        CHANGE: begin
          coin_rej <= coin_in;
          if (bus.chg_rdy) begin
            credit <= left[CREDIT_W-1:0];
            if (left == '0) state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
  assign bus.coin_rdy = state == ACCUM;
  assign bus.busy     = state != ACCUM;
  assign bus.item     = state == VEND;
  assign bus.chg_vld  = state == CHANGE;
  assign bus.chg_typ  = state == CHANGE ? sel : 2'b00;
  assign bus.credit   = credit;
  assign bus.coin_rej = coin_rej;
`ifdef SALES_CNT_EN
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) bus.sales_cnt <= '0;
    else if (state == VEND && bus.sales_cnt != 16'hFFFF) bus.sales_cnt <= bus.sales_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: table-driven scoreboard bench for vend_ctrl_param (default and CREDIT_W=4/PRICE=15 instances).
module tb_vend_ctrl_param;
  logic CLK = 1'b0;
  logic RES = 1'b0;
  always #5 CLK = ~CLK;
  vend_if #(.CREDIT_W(6)) bus ();
  vend_if #(.CREDIT_W(4)) bus4 ();
  vend_ctrl_param dut (.CLK(CLK), .RES(RES), .bus(bus.slave));
  vend_ctrl_param #(.CREDIT_W(4), .PRICE(15)) dut4 (.CLK(CLK), .RES(RES), .bus(bus4.slave));
  typedef struct {
    logic       vld;
    logic [1:0] typ;
    logic       cancel;
    logic       rdy;
    int         credit;
    logic       rej;
    logic       item;
    logic       chg;
    logic [1:0] ctyp;
    logic       busy;
  } vec_t;
  vec_t sb[$];
  vec_t tbl[$];
  int total = 0;
  int passed = 0;
  function automatic vec_t mk(logic vld, logic [1:0] typ, logic cancel, logic rdy, int credit,
                              logic rej, logic item, logic chg, logic [1:0] ctyp, logic busy);
    vec_t v;
    v.vld = vld; v.typ = typ; v.cancel = cancel; v.rdy = rdy; v.credit = credit;
    v.rej = rej; v.item = item; v.chg = chg; v.ctyp = ctyp; v.busy = busy;
    return v;
  endfunction
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic chk(input string tag, input vec_t e, input logic [31:0] cr, input logic rej, input logic item,
                     input logic chg, input logic [1:0] ct, input logic busy, input logic rdy);
    cmp({tag, " credit"}, cr, 32'(e.credit));
    cmp({tag, " coin_rej"}, 32'(rej), 32'(e.rej));
    cmp({tag, " item"}, 32'(item), 32'(e.item));
    cmp({tag, " chg_vld"}, 32'(chg), 32'(e.chg));
    cmp({tag, " chg_typ"}, 32'(ct), 32'(e.ctyp));
    cmp({tag, " busy"}, 32'(busy), 32'(e.busy));
    cmp({tag, " coin_rdy"}, 32'(rdy), 32'(!e.busy));
  endtask
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    bus.coin_vld = v.vld; bus.coin_typ = v.typ; bus.cancel = v.cancel; bus.chg_rdy = v.rdy;
    sb.push_back(v);
    @(posedge CLK); #1;
    e = sb.pop_front();
    chk(tag, e, 32'(bus.credit), bus.coin_rej, bus.item, bus.chg_vld, bus.chg_typ, bus.busy, bus.coin_rdy);
  endtask
  task automatic apply4(input string tag, input vec_t v);
    vec_t e;
    bus4.coin_vld = v.vld; bus4.coin_typ = v.typ; bus4.cancel = v.cancel; bus4.chg_rdy = v.rdy;
    sb.push_back(v);
    @(posedge CLK); #1;
    e = sb.pop_front();
    chk(tag, e, 32'(bus4.credit), bus4.coin_rej, bus4.item, bus4.chg_vld, bus4.chg_typ, bus4.busy, bus4.coin_rdy);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    bus.coin_vld = 0; bus.coin_typ = 0; bus.cancel = 0; bus.chg_rdy = 0;
    bus4.coin_vld = 0; bus4.coin_typ = 0; bus4.cancel = 0; bus4.chg_rdy = 0;
    // two pennies vend exactly; penny + five farthings leaves a farthing of change
    tbl.push_back(mk(1, 3, 0, 0,  8, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 16, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 1,  8, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 12, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 14, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 16, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 18, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1,  2, 0, 0, 1, 2, 1));
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    // coin+cancel at credit 3: reject, refund farthing then half-farthing
    tbl.push_back(mk(1, 2, 0, 0,  2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 1, 0,  3, 1, 0, 1, 2, 1));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0,  8, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 16, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 3, 0, 0,  0, 1, 0, 0, 0, 0));
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'(bus.credit), bus.coin_rej, bus.item,
        bus.chg_vld, bus.chg_typ, bus.busy, bus.coin_rdy);
    RES = 1'b1;
    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);
`ifdef SALES_CNT_EN
    cmp("sales_cnt after 3 vends", 32'(bus.sales_cnt), 32'd3);
`endif
    // change held stable while dispenser stalls
    apply("t3 farthing", mk(1, 2, 0, 0, 2, 0, 0, 0, 0, 0));
    apply("t3 cancel",   mk(0, 0, 1, 0, 2, 0, 0, 1, 2, 1));
    for (int k = 0; k < 3; k++) apply($sformatf("t3 hold%0d", k), mk(0, 0, 0, 0, 2, 0, 0, 1, 2, 1));
    apply("t3 release",  mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    bus.chg_rdy = 0;
    // 4-bit credit: overflow reject, then coin during change rejected
    apply4("t4 penny",    mk(1, 3, 0, 0, 8, 0, 0, 0, 0, 0));
    apply4("t4 overflow", mk(1, 3, 0, 0, 8, 1, 0, 0, 0, 0));
    apply4("t4 cancel",   mk(0, 0, 1, 0, 8, 0, 0, 1, 3, 1));
    apply4("t4 coin_chg", mk(1, 1, 0, 0, 8, 1, 0, 1, 3, 1));
    apply4("t4 drain",    mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    bus4.chg_rdy = 0;
    // asynchronous reset in the middle of a refund
    for (int k = 1; k <= 3; k++) apply($sformatf("t6 farthing%0d", k), mk(1, 2, 0, 0, 2 * k, 0, 0, 0, 0, 0));
    apply("t6 cancel", mk(0, 0, 1, 0, 6, 0, 0, 1, 2, 1));
    bus.cancel = 0;
    #3 RES = 1'b0;
    #1;
    cmp("t6 async credit", 32'(bus.credit), 32'd0);
    cmp("t6 async chg_vld", 32'(bus.chg_vld), 32'd0);
    cmp("t6 async chg_typ", 32'(bus.chg_typ), 32'd0);
    cmp("t6 async coin_rdy", 32'(bus.coin_rdy), 32'd1);
`ifdef SALES_CNT_EN
    cmp("t6 async sales_cnt", 32'(bus.sales_cnt), 32'd0);
`endif
    @(posedge CLK); #1;
    RES = 1'b1;
    apply("t6 after reset", mk(1, 3, 0, 0, 8, 0, 0, 0, 0, 0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
